mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external SRAM bus (address/byteenable/read/write/writedata/waitrequest/readdata/readdataready) between two requesters.
- m0 is the test controller's memory port; m1 is the host-side vector loader/result reader.
- Round-robin, per-transaction arbitration with optional lock for bursts.
- Pipelined reads are returned to the issuing master through a pending-ID FIFO.

Parameters:
ADDR_WIDTH, 20, SRAM word address width
DATA_WIDTH, 16, data width
BE_WIDTH, DATA_WIDTH/8, byteenable width
MAX_PENDING, 4, max outstanding reads (power of 2, >=2)

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  synchronous, active-high
mN_address  in  ADDR_WIDTH  master N address (N=0,1; same set for each)
mN_byteenable  in  BE_WIDTH  master N byteenables
mN_read  in  1  master N read request
mN_write  in  1  master N write request
mN_writedata  in  DATA_WIDTH  master N write data
mN_lock  in  1  hold grant after this transaction
mN_waitrequest  out  1  high = command not accepted this cycle
mN_readdata  out  DATA_WIDTH  read data to master N
mN_readdataready  out  1  read data valid for master N
address/byteenable/writedata  out  ADDR_WIDTH/BE_WIDTH/DATA_WIDTH  slave bus
read/write  out  1  slave command strobes
waitrequest  in  1  slave stall
readdata  in  DATA_WIDTH  slave read data
readdataready  in  1  slave read data valid, in-order
grant  out  2  one-hot current grant (00 idle)
rsp_error  out  1  sticky: readdataready with empty pending FIFO

Behaviour:
- Reset values: read=write=0, address/byteenable/writedata=0, grant=00, mN_waitrequest=1, mN_readdataready=0, mN_readdata=0, rsp_error=0, last_grant=m1 (so m0 wins first tie), pending FIFO empty.
- States: IDLE, OWN0, OWN1 (registered).
- IDLE: reqN = mN_read|mN_write. Both requesting -> grant master != last_grant. One requesting -> that master. Next state OWNx; no command issued in the IDLE cycle (1-cycle arbitration latency).
- OWNx: slave command = master x signals, combinational pass-through. Other master's waitrequest=1. mx_waitrequest = waitrequest | block. block = mx_read & fifo_full; while blocked, slave read forced 0.
- Accept = slave (read|write) & !waitrequest. Read accept pushes ID x into the pending FIFO the same cycle.
- After accept, mx_lock=1 -> stay OWNx.
- After accept, mx_lock=0: other master requesting -> OWN(other), last_grant=x. Otherwise, x still requesting next cycle -> stay. Neither requesting -> IDLE.
- Switching costs zero bubble cycles.
- OWNx with no request from x (lock released or idle): other requesting -> OWN(other), else IDLE.
- read and write both high from one master is illegal; write takes priority, read ignored.
- Response path: readdataready pops the FIFO head. mID_readdataready=1 and mID_readdata=readdata, registered (1-cycle latency from slave). The other master's readdataready stays 0 and its readdata holds.
- Push and pop in the same cycle are legal when the FIFO is full; count unchanged.
- readdataready with FIFO empty -> dropped, rsp_error set, cleared only by reset.
- Reset mid-operation: FIFO flushed, late readdataready after reset dropped and flagged (rsp_error=1). Bench must hold slave quiet after reset.
- Write data needs no response tracking.

Decomposition:
- Shared package (tester_pkg): grant encoding constants GNT_NONE/GNT_M0/GNT_M1, state encoding, default widths.
- One sub-module: pend_fifo (synchronous FIFO, width 1, depth MAX_PENDING, push/pop/full/empty/count, same clock/reset).

Test Plan:
- m0 writes addr 0x00010 data 0xA5A5, m1 idle -> grant=01 next cycle, slave write 1 cycle later, m0_waitrequest low on accept, back to IDLE.
- m0 and m1 request reads the same cycle out of reset -> m0 served first (grant=01), then m1 (grant=10) with no bubble. Slave returns 0x1111 then 0x2222 -> m0 gets 0x1111, m1 gets 0x2222, each 1 cycle after slave readdataready.
- Slave withholds readdataready; m0 issues 5 reads with MAX_PENDING=4 -> 5th stalls (m0_waitrequest=1, read=0) until first response, then accepted.
- m1_lock=1 over 3 writes while m0 requests -> m1 keeps grant for all 3; m0 granted on the cycle after the lock-free write.
- Slave waitrequest high 3 cycles during an m0 read -> address/read stable, m0_waitrequest=1 throughout, exactly one FIFO push.
- readdataready pulsed with nothing pending -> rsp_error=1 and stays set; reset asserted with 2 reads pending -> FIFO empty, grant=00, all reset values restored.

Source files
------------

// File: rtl/tester_pkg.sv
// Shared constants for the SRAM bus arbiter: grant encodings, FSM states and
// default bus widths.
package tester_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 20;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_MAX_PENDING = 4;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pend_fifo.sv
// Pending-read ID FIFO: records which master issued each outstanding read so
// in-order responses can be routed back.
module pend_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer, occupancy and storage update
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the external SRAM bus, with optional
// burst lock and in-order read response routing via a pending-ID FIFO.
module mem_arbiter
    import tester_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned MAX_PENDING = DEF_MAX_PENDING
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdataready,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdataready,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [BE_WIDTH-1:0]   byteenable,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic                  waitrequest,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  readdataready,
    output logic [1:0]            grant,
    output logic                  rsp_error
);

    arb_state_e state;
    logic       last_grant;   // 0 = m0 served last, 1 = m1 served last
    logic       req0;
    logic       req1;
    logic       accept;
    logic       push;
    logic       pop;
    logic       rd_block;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic [$clog2(MAX_PENDING):0] pend_count;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign accept = (read | write) & ~waitrequest;
    assign push   = read & ~waitrequest;
    assign pop    = readdataready & ~fifo_empty;

    // Owner's command passes straight through; a read is held off while the
    // pending FIFO is full, and write wins if both strobes are raised.
    always_comb begin
        address        = '0;
        byteenable     = '0;
        writedata      = '0;
        read           = 1'b0;
        write          = 1'b0;
        rd_block       = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state == ST_OWN0) begin
            rd_block       = m0_read & ~m0_write & fifo_full;
            address        = m0_address;
            byteenable     = m0_byteenable;
            writedata      = m0_writedata;
            write          = m0_write;
            read           = m0_read & ~m0_write & ~fifo_full;
            m0_waitrequest = waitrequest | rd_block;
        end else if (state == ST_OWN1) begin
            rd_block       = m1_read & ~m1_write & fifo_full;
            address        = m1_address;
            byteenable     = m1_byteenable;
            writedata      = m1_writedata;
            write          = m1_write;
            read           = m1_read & ~m1_write & ~fifo_full;
            m1_waitrequest = waitrequest | rd_block;
        end
    end

    // Arbitration FSM with registered grant
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= GNT_NONE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 && (!req1 || last_grant)) begin
                        state <= ST_OWN0;
                        grant <= GNT_M0;
                    end else if (req1) begin
                        state <= ST_OWN1;
                        grant <= GNT_M1;
                    end
                end
                ST_OWN0: begin
                    if ((accept && !m0_lock && req1) || (!accept && !req0 && req1)) begin
                        state      <= ST_OWN1;
                        grant      <= GNT_M1;
                        last_grant <= 1'b0;
                    end else if (!accept && !req0) begin
                        state <= ST_IDLE;
                        grant <= GNT_NONE;
                    end
                end
                ST_OWN1: begin
                    if ((accept && !m1_lock && req0) || (!accept && !req1 && req0)) begin
                        state      <= ST_OWN0;
                        grant      <= GNT_M0;
                        last_grant <= 1'b1;
                    end else if (!accept && !req1) begin
                        state <= ST_IDLE;
                        grant <= GNT_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Route each in-order response to the master recorded at the FIFO head
    always_ff @(posedge clock) begin
        if (reset) begin
            m0_readdataready <= 1'b0;
            m1_readdataready <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            rsp_error        <= 1'b0;
        end else begin
            m0_readdataready <= pop & ~fifo_head;
            m1_readdataready <= pop & fifo_head;
            if (pop && !fifo_head) begin
                m0_readdata <= readdata;
            end
            if (pop && fifo_head) begin
                m1_readdata <= readdata;
            end
            if (readdataready && (pend_count == '0)) begin
                rsp_error <= 1'b1;
            end
        end
    end

    pend_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_pend_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (state == ST_OWN1),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pend_count)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int MP = 4;

    logic          clock;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdataready, m1_readdataready;
    logic [AW-1:0] address;
    logic [BW-1:0] byteenable;
    logic          read, write;
    logic [DW-1:0] writedata;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdataready;
    logic [1:0]    grant;
    logic          rsp_error;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BE_WIDTH    (BW),
        .MAX_PENDING (MP)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_lock          (m0_lock),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdataready (m0_readdataready),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_lock          (m1_lock),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdataready (m1_readdataready),
        .address          (address),
        .byteenable       (byteenable),
        .read             (read),
        .write            (write),
        .writedata        (writedata),
        .waitrequest      (waitrequest),
        .readdata         (readdata),
        .readdataready    (readdataready),
        .grant            (grant),
        .rsp_error        (rsp_error)
    );

    always #5 clock = ~clock;

    int total;
    int bad;

    // Behavioural model: owner (0 none, 1 m0, 2 m1), last served master,
    // queue of pending read owners, registered response outputs.
    int            own;
    int            last;
    int            pend[$];
    bit            err;
    bit            rdv[2];
    logic [DW-1:0] rdat[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        own  = 0;
        last = 1;
        pend.delete();
        err  = 0;
        rdv[0] = 0; rdv[1] = 0;
        rdat[0] = '0; rdat[1] = '0;
    endtask

    function automatic logic f_rd(int x);     return (x == 0) ? m0_read : m1_read;             endfunction
    function automatic logic f_wr(int x);     return (x == 0) ? m0_write : m1_write;           endfunction
    function automatic logic f_lk(int x);     return (x == 0) ? m0_lock : m1_lock;             endfunction
    function automatic logic [AW-1:0] f_ad(int x); return (x == 0) ? m0_address : m1_address;  endfunction
    function automatic logic [BW-1:0] f_be(int x); return (x == 0) ? m0_byteenable : m1_byteenable; endfunction
    function automatic logic [DW-1:0] f_wd(int x); return (x == 0) ? m0_writedata : m1_writedata;   endfunction

    // One clock: compare every output against the model at the falling edge,
    // then advance the model with the inputs the DUT samples at the next rise.
    task automatic cycle();
        int            x;
        bit            e_rd, e_wr, e_w0, e_w1, rd, full, acc, r0, r1, xr, orq;
        logic [AW-1:0] e_ad;
        logic [BW-1:0] e_be;
        logic [DW-1:0] e_wd;
        @(negedge clock);
        x = own - 1;
        e_rd = 0; e_wr = 0; e_w0 = 1; e_w1 = 1; e_ad = '0; e_be = '0; e_wd = '0;
        if (own != 0) begin
            rd   = f_rd(x) && !f_wr(x);
            full = (pend.size() == MP);
            e_wr = f_wr(x);
            e_rd = rd && !full;
            e_ad = f_ad(x); e_be = f_be(x); e_wd = f_wd(x);
            if (x == 0) e_w0 = waitrequest || (rd && full);
            else        e_w1 = waitrequest || (rd && full);
        end
        chk("grant", grant, (own == 0) ? 32'd0 : (own == 1) ? 32'd1 : 32'd2);
        chk("read", read, e_rd);
        chk("write", write, e_wr);
        chk("address", address, e_ad);
        chk("byteenable", byteenable, e_be);
        chk("writedata", writedata, e_wd);
        chk("m0_waitrequest", m0_waitrequest, e_w0);
        chk("m1_waitrequest", m1_waitrequest, e_w1);
        chk("m0_readdataready", m0_readdataready, rdv[0]);
        chk("m1_readdataready", m1_readdataready, rdv[1]);
        chk("m0_readdata", m0_readdata, rdat[0]);
        chk("m1_readdata", m1_readdata, rdat[1]);
        chk("rsp_error", rsp_error, err);
        if (reset) begin
            model_reset();
        end else begin
            acc = (e_rd || e_wr) && !waitrequest;
            rdv[0] = 0; rdv[1] = 0;
            if (readdataready) begin
                if (pend.size() > 0) begin
                    int id;
                    id = pend.pop_front();
                    rdv[id]  = 1;
                    rdat[id] = readdata;
                end else begin
                    err = 1;
                end
            end
            if (e_rd && !waitrequest) pend.push_back(x);
            r0 = m0_read || m0_write;
            r1 = m1_read || m1_write;
            if (own == 0) begin
                if (r0 && r1)  own = (last == 1) ? 1 : 2;
                else if (r0)   own = 1;
                else if (r1)   own = 2;
            end else begin
                xr  = (x == 0) ? r0 : r1;
                orq = (x == 0) ? r1 : r0;
                if (acc) begin
                    if (!f_lk(x) && orq) begin last = x; own = 2 - x; end
                end else if (!xr) begin
                    if (orq) begin last = x; own = 2 - x; end
                    else own = 0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive_random();
        m0_read       = ($urandom_range(0, 2) == 0);
        m0_write      = ($urandom_range(0, 3) == 0);
        m0_lock       = ($urandom_range(0, 5) == 0);
        m0_address    = AW'($urandom);
        m0_byteenable = BW'($urandom);
        m0_writedata  = DW'($urandom);
        m1_read       = ($urandom_range(0, 2) == 0);
        m1_write      = ($urandom_range(0, 3) == 0);
        m1_lock       = ($urandom_range(0, 5) == 0);
        m1_address    = AW'($urandom);
        m1_byteenable = BW'($urandom);
        m1_writedata  = DW'($urandom);
        waitrequest   = ($urandom_range(0, 3) == 0);
        readdataready = (pend.size() > 0) && ($urandom_range(0, 4) < 2);
        readdata      = DW'($urandom);
        reset         = ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        total = 0; bad = 0;
        clock = 0; reset = 1;
        m0_address = '0; m0_byteenable = 2'b11; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
        m1_address = '0; m1_byteenable = 2'b11; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
        waitrequest = 0; readdata = '0; readdataready = 0;
        model_reset();
        @(posedge clock); #1;
        cycle();
        chk("rst grant", grant, 2'b00);
        chk("rst m0_wait", m0_waitrequest, 1'b1);
        chk("rst m1_wait", m1_waitrequest, 1'b1);
        chk("rst read", read, 1'b0);
        chk("rst rsp_error", rsp_error, 1'b0);
        reset = 0;

        // Single m0 write
        m0_write = 1; m0_address = 20'h00010; m0_writedata = 16'hA5A5;
        #1 chk("t1 idle write", write, 1'b0);
        cycle();
        #1 chk("t1 grant", grant, 2'b01);
        chk("t1 write", write, 1'b1);
        chk("t1 address", address, 20'h00010);
        chk("t1 writedata", writedata, 16'hA5A5);
        chk("t1 m0_wait", m0_waitrequest, 1'b0);
        cycle();
        m0_write = 0;
        cycle();
        #1 chk("t1 back idle", grant, 2'b00);

        // Simultaneous reads out of reset
        reset = 1; cycle(); reset = 0;
        m0_read = 1; m0_address = 20'h00001;
        m1_read = 1; m1_address = 20'h00002;
        cycle();
        #1 chk("t2 grant m0", grant, 2'b01);
        chk("t2 addr m0", address, 20'h00001);
        cycle();
        m0_read = 0;
        #1 chk("t2 grant m1", grant, 2'b10);
        chk("t2 addr m1", address, 20'h00002);
        chk("t2 read m1", read, 1'b1);
        cycle();
        m1_read = 0; readdataready = 1; readdata = 16'h1111;
        cycle();
        readdata = 16'h2222;
        #1 chk("t2 m0 rdv", m0_readdataready, 1'b1);
        chk("t2 m0 rdata", m0_readdata, 16'h1111);
        chk("t2 m1 rdv low", m1_readdataready, 1'b0);
        cycle();
        readdataready = 0;
        #1 chk("t2 m1 rdv", m1_readdataready, 1'b1);
        chk("t2 m1 rdata", m1_readdata, 16'h2222);
        chk("t2 m0 rdata hold", m0_readdata, 16'h1111);
        cycle();

        // Pending FIFO full: fifth read stalls until a response pops
        m0_read = 1; m0_address = 20'h00040;
        cycle();
        repeat (4) cycle();
        #1 chk("t3 blocked read", read, 1'b0);
        chk("t3 blocked wait", m0_waitrequest, 1'b1);
        cycle();
        #1 chk("t3 still blocked", read, 1'b0);
        readdataready = 1; readdata = 16'h3333;
        cycle();
        readdataready = 0;
        #1 chk("t3 unblocked read", read, 1'b1);
        chk("t3 unblocked wait", m0_waitrequest, 1'b0);
        chk("t3 first rsp", m0_readdata, 16'h3333);
        cycle();
        m0_read = 0; readdataready = 1;
        repeat (4) cycle();
        readdataready = 0;
        cycle();
        #1 chk("t3 no error", rsp_error, 1'b0);

        // m1 locked burst of 3 writes while m0 waits
        m1_write = 1; m1_lock = 1; m1_address = 20'h00200; m1_writedata = 16'hBEEF;
        cycle();
        m0_write = 1; m0_address = 20'h00300; m0_writedata = 16'hCAFE;
        #1 chk("t4 w1 grant", grant, 2'b10);
        cycle();
        #1 chk("t4 w2 grant", grant, 2'b10);
        cycle();
        m1_lock = 0;
        #1 chk("t4 w3 grant", grant, 2'b10);
        chk("t4 m0 held", m0_waitrequest, 1'b1);
        cycle();
        m1_write = 0;
        #1 chk("t4 m0 grant", grant, 2'b01);
        chk("t4 m0 addr", address, 20'h00300);
        cycle();
        m0_write = 0;
        repeat (2) cycle();

        // Slave stall on an m0 read, then a spurious response
        m0_read = 1; m0_address = 20'h00123;
        cycle();
        waitrequest = 1;
        repeat (3) begin
            #1 chk("t5 stall read", read, 1'b1);
            chk("t5 stall addr", address, 20'h00123);
            chk("t5 stall wait", m0_waitrequest, 1'b1);
            cycle();
        end
        waitrequest = 0;
        #1 chk("t5 accept", m0_waitrequest, 1'b0);
        cycle();
        m0_read = 0; readdataready = 1; readdata = 16'h4444;
        cycle();
        readdata = 16'h5555;
        #1 chk("t5 rsp", m0_readdata, 16'h4444);
        chk("t5 err clear", rsp_error, 1'b0);
        cycle();
        readdataready = 0;
        #1 chk("t5 err set", rsp_error, 1'b1);
        repeat (3) cycle();
        #1 chk("t5 err sticky", rsp_error, 1'b1);

        // Reset with two reads outstanding, then a late response
        reset = 1; cycle(); reset = 0;
        m0_read = 1; m0_address = 20'h00050;
        repeat (3) cycle();
        m0_read = 0; reset = 1;
        cycle();
        reset = 0;
        #1 chk("t6 grant", grant, 2'b00);
        chk("t6 err", rsp_error, 1'b0);
        chk("t6 m0_wait", m0_waitrequest, 1'b1);
        repeat (2) cycle();
        readdataready = 1;
        cycle();
        readdataready = 0;
        #1 chk("t6 late rsp flagged", rsp_error, 1'b1);
        reset = 1; cycle(); reset = 0;

        // Randomized traffic
        repeat (3000) begin
            drive_random();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
